// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage itself takes the slave view; the surrounding pipeline/testbench takes the master view.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              up_valid;
  logic              up_ready;
  logic [CTRL_W-1:0] up_ctrl;
  logic [DATA_W-1:0] up_data;
  logic [PC_W-1:0]   up_pc;
  logic              up_is_bds;

  logic              dn_valid;
  logic              dn_ready;
  logic [CTRL_W-1:0] dn_ctrl;
  logic [DATA_W-1:0] dn_data;
  logic [PC_W-1:0]   dn_restart_pc;
  logic              dn_is_bds;
  logic              dn_is_flushed;

  modport slave (
    input  up_valid, up_ctrl, up_data, up_pc, up_is_bds, dn_ready,
    output up_ready, dn_valid, dn_ctrl, dn_data, dn_restart_pc, dn_is_bds, dn_is_flushed
  );

  modport master (
    output up_valid, up_ctrl, up_data, up_pc, up_is_bds, dn_ready,
    input  up_ready, dn_valid, dn_ctrl, dn_data, dn_restart_pc, dn_is_bds, dn_is_flushed
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with optional skid entry so up_ready is registered.
// Supports per-word flush marking, delay-slot restart PC tracking and a whole-stage kill.
module pipe_stage_elastic #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int SKID   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  pipe_stage_elastic_if.slave  bus,
  input  logic                 flush,
  input  logic                 kill,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   restart_pc;
    logic              is_bds;
    logic              is_flushed;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // A flushed word becomes a NOP but keeps its data; a delay slot restarts at its branch.
  function automatic entry_t capture(
    input logic [CTRL_W-1:0] ctrl,
    input logic [DATA_W-1:0] data,
    input logic [PC_W-1:0]   pc,
    input logic              is_bds,
    input logic              flushed,
    input logic [PC_W-1:0]   last_restart
  );
    entry_t e;
    e.ctrl       = flushed ? '0 : ctrl;
    e.data       = data;
    e.restart_pc = is_bds ? last_restart : pc;
    e.is_bds     = is_bds;
    e.is_flushed = flushed;
    return e;
  endfunction

  state_t          state_q, state_d;
  entry_t          main_p1, skid_p1, cap_word;
  logic [PC_W-1:0] last_restart_p1;
  logic            up_ready, dn_valid;
  logic            accept, pop;
  logic            load_main, load_skid, skid_to_main;

  assign accept   = bus.up_valid & up_ready;
  assign pop      = dn_valid & bus.dn_ready;
  assign cap_word = capture(bus.up_ctrl, bus.up_data, bus.up_pc, bus.up_is_bds,
                            flush, last_restart_p1);

  generate
    if (SKID != 0) begin : g_skid
      logic up_ready_q;
      // Registered ready: it only drops when the next state holds both entries.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) up_ready_q <= 1'b0;
        else       up_ready_q <= (state_d != TWO);
      end
      assign up_ready = up_ready_q;
    end else begin : g_noskid
      assign up_ready = bus.dn_ready | ~dn_valid;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop && (SKID != 0)) state_d = TWO;
          else if (!accept && pop)           state_d = EMPTY;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    dn_valid     = (state_q != EMPTY);
    occupancy    = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (!kill) begin
      case (state_q)
        EMPTY: load_main = accept;
        ONE: begin
          load_main = accept & pop;
          load_skid = accept & ~pop;
        end
        TWO:     skid_to_main = pop;
        default: ;
      endcase
    end
  end

  // Stage boundary: entries only change on a load, so a stalled head stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_p1         <= '0;
      skid_p1         <= '0;
      last_restart_p1 <= '0;
    end else begin
      if (load_main)         main_p1 <= cap_word;
      else if (skid_to_main) main_p1 <= skid_p1;
      if (load_skid)         skid_p1 <= cap_word;
      if (accept && !bus.up_is_bds && !kill) last_restart_p1 <= bus.up_pc;
    end
  end

  assign bus.up_ready      = up_ready;
  assign bus.dn_valid      = dn_valid;
  assign bus.dn_ctrl       = main_p1.ctrl;
  assign bus.dn_data       = main_p1.data;
  assign bus.dn_restart_pc = main_p1.restart_pc;
  assign bus.dn_is_bds     = main_p1.is_bds;
  assign bus.dn_is_flushed = main_p1.is_flushed;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: stimulus pushes hand-computed expected words into a
// scoreboard; a negedge monitor pops and compares on every downstream handshake.
module tb_pipe_stage_elastic;
  localparam int CW = 32;
  localparam int DW = 32;
  localparam int PW = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       kill  = 1'b0;
  logic [1:0] occupancy;
  int         cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW)) bus ();

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .SKID(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .kill      (kill),
    .occupancy (occupancy)
  );

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic [PW-1:0] rpc;
    logic          bds;
    logic          fl;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.dn_valid && bus.dn_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got ctrl %0h expected no word", bus.dn_ctrl);
      end else begin
        e = sb.pop_front();
        chk("word", {bus.dn_ctrl, bus.dn_data, bus.dn_restart_pc, bus.dn_is_bds, bus.dn_is_flushed}, e);
      end
    end
  end

  // Offer one word until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] c, input logic [31:0] d, input logic [31:0] p,
                      input logic b, input logic f, input logic [31:0] ec, input logic [31:0] erpc);
    bit ok;
    ok = 0;
    bus.up_valid = 1'b1; bus.up_ctrl = c; bus.up_data = d; bus.up_pc = p;
    bus.up_is_bds = b; flush = f;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      if (bus.up_ready) ok = 1;
      @(posedge clock);
    end
    if (ok) sb.push_back({ec, d, erpc, b, f});
    else begin
      total++;
      $display("FAIL send_timeout: got no accept for ctrl %0h expected accept", c);
    end
    #1;
    bus.up_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int c0;
    bus.up_valid = 0; bus.up_ctrl = 0; bus.up_data = 0; bus.up_pc = 0;
    bus.up_is_bds = 0; bus.dn_ready = 0;

    #12;
    chk("reset_up_ready", bus.up_ready, 0);
    chk("reset_dn_valid", bus.dn_valid, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_dn_ctrl", bus.dn_ctrl, 0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock) #1;
    chk("up_ready_after_release", bus.up_ready, 1);

    // delay slot as first word after reset restarts at 0
    bus.dn_ready = 1'b1;
    send(32'hB0, 32'h604, 32'h600, 1, 0, 32'hB0, 32'h0);
    idle(1);

    // streaming
    send(32'h11, 32'h14, 32'h10, 0, 0, 32'h11, 32'h10);
    chk("latency_dn_valid", bus.dn_valid, 1);
    chk("latency_dn_ctrl", bus.dn_ctrl, 32'h11);
    c0 = cyc;
    send(32'h22, 32'h18, 32'h14, 0, 0, 32'h22, 32'h14);
    send(32'h33, 32'h1C, 32'h18, 0, 0, 32'h33, 32'h18);
    chk("stream_back_to_back", cyc - c0, 2);
    idle(2);
    chk("stream_drained_occ", occupancy, 0);

    // backpressure
    bus.dn_ready = 1'b0;
    send(32'hA1, 32'h24, 32'h20, 0, 0, 32'hA1, 32'h20);
    send(32'hA2, 32'h28, 32'h24, 0, 0, 32'hA2, 32'h24);
    bus.up_valid = 1'b1; bus.up_ctrl = 32'hA3; bus.up_data = 32'h2C; bus.up_pc = 32'h28;
    idle(1);
    chk("bp_occupancy", occupancy, 2);
    chk("bp_up_ready", bus.up_ready, 0);
    chk("bp_head_stable0", bus.dn_ctrl, 32'hA1);
    idle(1);
    chk("bp_head_stable1", {bus.dn_ctrl, bus.dn_data}, {32'hA1, 32'h24});
    bus.dn_ready = 1'b1;
    c0 = cyc;
    send(32'hA3, 32'h2C, 32'h28, 0, 0, 32'hA3, 32'h28);
    chk("bp_resume_cycles", cyc - c0, 2);
    idle(1);
    chk("bp_drained_occ", occupancy, 0);

    // flush: control cleared, data kept
    send(32'hDEAD, 32'h104, 32'h200, 0, 1, 32'h0, 32'h200);
    chk("flush_fields", {bus.dn_ctrl, bus.dn_data, bus.dn_is_flushed}, {32'h0, 32'h104, 1'b1});
    idle(1);

    // restart PC across a delay slot
    send(32'h1, 32'h104, 32'h100, 0, 0, 32'h1, 32'h100);
    send(32'h2, 32'h108, 32'h104, 1, 0, 32'h2, 32'h100);
    send(32'h3, 32'h10C, 32'h108, 0, 0, 32'h3, 32'h108);
    idle(2);

    // kill with both entries held and a word pending upstream
    bus.dn_ready = 1'b0;
    send(32'hC1, 32'h304, 32'h300, 0, 0, 32'hC1, 32'h300);
    send(32'hC2, 32'h308, 32'h304, 0, 0, 32'hC2, 32'h304);
    bus.up_valid = 1'b1; bus.up_ctrl = 32'hC3; bus.up_data = 32'h30C; bus.up_pc = 32'h308;
    kill = 1'b1;
    idle(1);
    kill = 1'b0;
    sb.delete();
    chk("kill2_occupancy", occupancy, 0);
    chk("kill2_dn_valid", bus.dn_valid, 0);
    chk("kill2_up_ready", bus.up_ready, 1);
    bus.dn_ready = 1'b1;
    send(32'hC3, 32'h30C, 32'h308, 0, 0, 32'hC3, 32'h308);
    chk("post_kill_word", bus.dn_ctrl, 32'hC3);
    idle(2);

    // kill with a concurrent accept: that word is discarded and leaves last_restart alone
    bus.dn_ready = 1'b0;
    send(32'hD1, 32'h404, 32'h400, 0, 0, 32'hD1, 32'h400);
    bus.up_valid = 1'b1; bus.up_ctrl = 32'hD2; bus.up_data = 32'h504; bus.up_pc = 32'h500;
    bus.up_is_bds = 1'b0; kill = 1'b1;
    @(negedge clock);
    chk("kill1_accept_ready", bus.up_ready, 1);
    @(posedge clock) #1;
    kill = 1'b0; bus.up_valid = 1'b0;
    sb.delete();
    chk("kill1_occupancy", occupancy, 0);
    chk("kill1_dn_valid", bus.dn_valid, 0);
    bus.dn_ready = 1'b1;
    send(32'hD3, 32'h508, 32'h504, 1, 0, 32'hD3, 32'h400);
    idle(2);

    // reset mid-traffic takes effect immediately
    bus.dn_ready = 1'b0;
    send(32'hE1, 32'h804, 32'h800, 0, 0, 32'hE1, 32'h800);
    send(32'hE2, 32'h808, 32'h804, 0, 0, 32'hE2, 32'h804);
    chk("pre_reset_occ", occupancy, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_dn_valid", bus.dn_valid, 0);
    chk("async_reset_occ", occupancy, 0);
    chk("async_reset_up_ready", bus.up_ready, 0);
    sb.delete();
    @(negedge clock) reset = 1'b0;
    bus.dn_ready = 1'b1;
    send(32'hF1, 32'h704, 32'h700, 1, 0, 32'hF1, 32'h0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clock);
    idle(1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
